// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter-side signal bundle for uart_tx_arbiter.
// The arbiter connects through the slave modport; producers and the transmitter connect through master.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int GID_W   = 2
);
  // Handshake: a requester raises i_Req_Valid[k] with its byte on i_Req_Data[8k+:8]
  // and holds both until o_Req_Ready[k] pulses for one cycle; that pulse is the accept.
  // Dropping valid before the pulse withdraws the request. o_Tx_DV stays high until
  // the transmitter answers with i_Tx_Active; i_Tx_Done marks frame end (2 cycles).
  logic [NUM_REQ-1:0]   i_Req_Valid;
  logic [8*NUM_REQ-1:0] i_Req_Data;
  logic [NUM_REQ-1:0]   o_Req_Ready;
  logic                 o_Tx_DV;
  logic [7:0]           o_Tx_Byte;
  logic                 i_Tx_Active;
  logic                 i_Tx_Done;
  logic [GID_W-1:0]     o_Grant_Id;
  logic                 o_Busy;
  logic                 o_Timeout;
  logic [1:0]           o_Dbg_State;

  modport slave (
    input  i_Req_Valid, i_Req_Data, i_Tx_Active, i_Tx_Done,
    output o_Req_Ready, o_Tx_DV, o_Tx_Byte, o_Grant_Id, o_Busy, o_Timeout, o_Dbg_State
  );

  modport master (
    output i_Req_Valid, i_Req_Data, i_Tx_Active, i_Tx_Done,
    input  o_Req_Ready, o_Tx_DV, o_Tx_Byte, o_Grant_Id, o_Busy, o_Timeout, o_Dbg_State
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ producers.
// Optional launch-to-done abort timer is enabled with `define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int GID_W        = 2,
  parameter int TIMEOUT_CLKS = 13020
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  uart_tx_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic                 dv_q, dv_d;
  logic [7:0]           byte_q, byte_d;
  logic [GID_W-1:0]     grant_q, grant_d;
  logic [GID_W-1:0]     last_q, last_d;
  logic                 done_prev_q, done_prev_d;
  logic                 done_rise;
  logic                 found;
  logic [GID_W-1:0]     pick;
  logic [GID_W-1:0]     cand;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;
`endif

  assign done_prev_d = bus.i_Tx_Done;
  assign done_rise   = bus.i_Tx_Done && !done_prev_q;

  // Search upward from the slot after the last grant, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GID_W'((int'(last_q) + i) % NUM_REQ);
      if (!found && bus.i_Req_Valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ready_d = '0;
    dv_d    = dv_q;
    byte_d  = byte_q;
    grant_d = grant_q;
    last_d  = last_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          ready_d[pick] = 1'b1;
          dv_d          = 1'b1;
          byte_d        = bus.i_Req_Data[{pick, 3'b000} +: 8];
          grant_d       = pick;
          last_d        = pick;
          state_d       = S_LAUNCH;
`ifdef UART_TX_ARB_TIMEOUT_EN
          cnt_d         = '0;
`endif
        end
      end
      S_LAUNCH: begin
        if (bus.i_Tx_Active) begin
          dv_d    = 1'b0;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // Only the first Done cycle counts; the second is absorbed by S_GAP.
        if (done_rise) state_d = S_GAP;
      end
      S_GAP: begin
        if (!bus.i_Tx_Done && !bus.i_Tx_Active) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef UART_TX_ARB_TIMEOUT_EN
    if (state_q == S_LAUNCH || state_q == S_WAIT_DONE) begin
      cnt_d = cnt_q + 1'b1;
      if (!(state_q == S_WAIT_DONE && done_rise) && cnt_q == CNT_W'(TIMEOUT_CLKS - 1)) begin
        timeout_d = 1'b1;
        dv_d      = 1'b0;
        state_d   = S_GAP;
      end
    end
`endif
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= S_IDLE;
      ready_q     <= '0;
      dv_q        <= 1'b0;
      byte_q      <= '0;
      grant_q     <= '0;
      last_q      <= GID_W'(NUM_REQ - 1);
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      dv_q        <= dv_d;
      byte_q      <= byte_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      done_prev_q <= done_prev_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.o_Timeout = timeout_q;
`else
  assign bus.o_Timeout = 1'b0;
`endif

  assign bus.o_Req_Ready = ready_q;
  assign bus.o_Tx_DV     = dv_q;
  assign bus.o_Tx_Byte   = byte_q;
  assign bus.o_Grant_Id  = grant_q;
  assign bus.o_Busy      = (state_q != S_IDLE);
  assign bus.o_Dbg_State = state_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: four requesters and a 4-clocks-per-bit transmitter model.
module tb_uart_tx_arbiter;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_LAUNCH = 2'd1, ST_WAIT = 2'd2, ST_GAP = 2'd3;
  localparam int FRAME_CLKS = 40;

  logic clk, rst;
  int   cyc;
  bit   tx_en;
  logic [7:0] req_data [4];
  int   issued [4];
  int   acked  [4];
  int   pulses [4];
  logic [3:0] man_valid;
  logic [3:0] req_valid;
  logic [14:0] exp_q[$];
  logic [7:0]  exp_tx_q[$];
  int total, bad, frames, grants, grant_cyc, done_cyc;
  logic tx_active, tx_done;

  uart_tx_arbiter_if #(.NUM_REQ(4), .GID_W(2)) bus();

  uart_tx_arbiter #(.NUM_REQ(4), .GID_W(2), .TIMEOUT_CLKS(50)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always_comb begin
    for (int k = 0; k < 4; k++) req_valid[k] = (issued[k] != acked[k]) | man_valid[k];
  end
  assign bus.i_Req_Valid = req_valid;
  assign bus.i_Req_Data  = {req_data[3], req_data[2], req_data[1], req_data[0]};
  assign bus.i_Tx_Active = tx_active;
  assign bus.i_Tx_Done   = tx_done;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic issue(input int k, input logic [7:0] b);
    req_data[k] = b;
    issued[k]++;
  endtask

  task automatic push_grant(input int k, input logic [7:0] b, input bit tx);
    logic [3:0] oh;
    oh = 4'b0001 << k;
    exp_q.push_back({1'b1, oh, 2'(k), b});
    if (tx) exp_tx_q.push_back(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!bus.o_Busy && req_valid == 4'b0) ok = 1'b1;
    end
    check("wait_idle", 32'(ok), 32'd1);
  endtask

  task automatic wait_grants(input int target, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (grants >= target) ok = 1'b1;
    end
    check("wait_grants", 32'(ok), 32'd1);
  endtask

  // scoreboard monitor: every Ready pulse must match the head of exp_q
  initial begin
    logic [14:0] got, exp;
    forever begin
      @(negedge clk);
      if (!rst && bus.o_Req_Ready != 4'b0) begin
        got = {bus.o_Tx_DV, bus.o_Req_Ready, bus.o_Grant_Id, bus.o_Tx_Byte};
        grants++;
        grant_cyc = cyc;
        for (int k = 0; k < 4; k++) if (bus.o_Req_Ready[k]) begin
          pulses[k]++;
          acked[k]++;
        end
        if (exp_q.size() == 0) check("unexpected_grant", 32'(got), 32'h0);
        else begin
          exp = exp_q.pop_front();
          check("grant", 32'(got), 32'(exp));
        end
      end
    end
  end

  // transmitter model: Active for 10 bits x 4 clks, then Done for 2 cycles
  initial begin
    int m_st, m_cnt;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    m_st = 0;
    m_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_active = 1'b0;
        tx_done   = 1'b0;
        m_st = 0;
      end else begin
        case (m_st)
          0: if (tx_en && bus.o_Tx_DV) begin
            tx_active = 1'b1;
            m_cnt = 0;
            m_st = 1;
            frames++;
            if (exp_tx_q.size() == 0) check("unexpected_frame", 32'(bus.o_Tx_Byte), 32'h0);
            else check("tx_byte", 32'(bus.o_Tx_Byte), 32'(exp_tx_q.pop_front()));
          end
          1: begin
            m_cnt++;
            if (m_cnt == FRAME_CLKS) begin
              tx_active = 1'b0;
              tx_done   = 1'b1;
              done_cyc  = cyc;
              m_cnt = 0;
              m_st = 2;
              check("state_before_done", 32'(bus.o_Dbg_State), 32'(ST_WAIT));
            end
          end
          default: begin
            m_cnt++;
            check("state_in_done", 32'(bus.o_Dbg_State), 32'(ST_GAP));
            if (m_cnt == 2) begin
              tx_done = 1'b0;
              m_st = 0;
            end
          end
        endcase
      end
    end
  end

  initial begin
    int f0, g0, p1;
    bit seen_to;
    rst = 1'b1;
    tx_en = 1'b1;
    man_valid = 4'b0;
    total = 0; bad = 0; frames = 0; grants = 0; grant_cyc = 0; done_cyc = 0; cyc = 0;
    for (int k = 0; k < 4; k++) begin
      req_data[k] = 8'h00; issued[k] = 0; acked[k] = 0; pulses[k] = 0;
    end
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.o_Req_Ready, bus.o_Tx_DV, bus.o_Tx_Byte, bus.o_Grant_Id,
                            bus.o_Busy, bus.o_Timeout, bus.o_Dbg_State}, 32'h0);
    rst = 1'b0;

    // single request from requester 2
    @(negedge clk);
    push_grant(2, 8'hA5, 1'b1);
    issue(2, 8'hA5);
    @(posedge clk); #1;
    check("t1_ready", 32'(bus.o_Req_Ready), 32'h4);
    check("t1_dv", 32'(bus.o_Tx_DV), 32'd1);
    check("t1_byte_gid", {bus.o_Tx_Byte, 6'(bus.o_Grant_Id)}, {8'hA5, 6'd2});
    check("t1_busy", 32'(bus.o_Busy), 32'd1);
    @(posedge clk); #1;
    check("t1_dv_drop", {bus.o_Tx_DV, bus.o_Req_Ready, bus.o_Dbg_State}, {1'b0, 4'b0, ST_WAIT});
    wait_idle(200);
    check("t1_frames", 32'(frames), 32'd1);
    check("t1_busy_low", 32'(bus.o_Busy), 32'd0);

    // fairness with all four held valid, requester 0 sends twice
    do_reset();
    f0 = frames;
    push_grant(0, 8'h10, 1'b1);
    push_grant(1, 8'h11, 1'b1);
    push_grant(2, 8'h12, 1'b1);
    push_grant(3, 8'h13, 1'b1);
    push_grant(0, 8'h10, 1'b1);
    issue(0, 8'h10); issue(0, 8'h10);
    issue(1, 8'h11); issue(2, 8'h12); issue(3, 8'h13);
    wait_idle(1000);
    check("fair_frames", 32'(frames - f0), 32'd5);

    // Done double-count: next grant exactly 4 cycles after Done first appears
    g0 = grants;
    push_grant(1, 8'h21, 1'b1);
    push_grant(2, 8'h22, 1'b1);
    issue(1, 8'h21); issue(2, 8'h22);
    wait_grants(g0 + 2, 300);
    check("gap_cycles", 32'(grant_cyc - done_cyc), 32'd4);
    wait_idle(300);

    // withdrawal: requester 1 appears and vanishes while requester 0 transmits
    g0 = grants;
    p1 = pulses[1];
    push_grant(0, 8'h40, 1'b1);
    issue(0, 8'h40);
    wait_grants(g0 + 1, 50);
    req_data[1] = 8'h77;
    man_valid[1] = 1'b1;
    repeat (5) @(negedge clk);
    man_valid[1] = 1'b0;
    push_grant(3, 8'h33, 1'b1);
    issue(3, 8'h33);
    wait_idle(300);
    check("withdraw_no_ready1", 32'(pulses[1] - p1), 32'd0);

    // reset in the middle of a frame
    push_grant(2, 8'h5A, 1'b1);
    issue(2, 8'h5A);
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
        @(negedge clk);
        if (bus.o_Dbg_State == ST_WAIT) ok = 1'b1;
      end
      check("reach_wait_done", 32'(ok), 32'd1);
    end
    #2 rst = 1'b1;
    #1;
    check("midframe_reset", {bus.o_Req_Ready, bus.o_Tx_DV, bus.o_Tx_Byte, bus.o_Grant_Id,
                             bus.o_Busy, bus.o_Timeout, bus.o_Dbg_State}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_grant(0, 8'h01, 1'b1);
    push_grant(3, 8'h03, 1'b1);
    issue(0, 8'h01); issue(3, 8'h03);
    wait_idle(300);

    // stuck transmitter
    do_reset();
    tx_en = 1'b0;
    push_grant(1, 8'h61, 1'b0);
    issue(1, 8'h61);
    seen_to = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int i = 0; i < 200 && !seen_to; i++) begin
      @(negedge clk);
      if (bus.o_Timeout) seen_to = 1'b1;
    end
    check("timeout_seen", 32'(seen_to), 32'd1);
    check("timeout_latency", 32'(cyc - grant_cyc), 32'd50);
    check("timeout_dv_state", {bus.o_Tx_DV, bus.o_Dbg_State}, {1'b0, ST_GAP});
    @(negedge clk);
    check("timeout_one_cycle", 32'(bus.o_Timeout), 32'd0);
    tx_en = 1'b1;
    push_grant(2, 8'h72, 1'b1);
    push_grant(0, 8'h70, 1'b1);
    issue(0, 8'h70); issue(2, 8'h72);
    wait_idle(400);
`else
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.o_Timeout) seen_to = 1'b1;
    end
    check("no_timeout", 32'(seen_to), 32'd0);
    check("stuck_busy_dv", {bus.o_Busy, bus.o_Tx_DV, bus.o_Dbg_State}, {1'b1, 1'b1, ST_LAUNCH});
    do_reset();
    tx_en = 1'b1;
`endif

    repeat (5) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("exp_tx_q_empty", 32'(exp_tx_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART byte transmitter among NUM_REQ byte producers, such as camera status, debug and telemetry sources.
- Grants are round-robin. For each grant it latches the byte, drives the transmitter's DV/byte inputs, and tracks the frame through Active/Done.
- It then waits for the transmitter to return to idle before granting again.
- It sits between the producers and the transmitter, in the transmitter's 125 MHz domain.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- GID_W, 2: grant-id width. Must satisfy 2**GID_W >= NUM_REQ.
- TIMEOUT_CLKS, 13020: clocks allowed from launch to Done before abort (12 bit-times at 1085 clks/bit). Used only with the optional feature.

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  reset; asynchronous, active-high.
- i_Req_Valid  in  NUM_REQ  per-requester byte-valid level.
- i_Req_Data  in  8*NUM_REQ  requester k's byte on bits [8k+7:8k].
- o_Req_Ready  out  NUM_REQ  one-hot, one-cycle accept pulse to the granted requester.
- o_Tx_DV  out  1  data-valid to the transmitter.
- o_Tx_Byte  out  8  byte to the transmitter.
- i_Tx_Active  in  1  transmitter busy.
- i_Tx_Done  in  1  transmitter done; high for 2 consecutive cycles per frame.
- o_Grant_Id  out  GID_W  index of the current or last granted requester.
- o_Busy  out  1  high in every state except S_IDLE.
- o_Timeout  out  1  one-cycle abort pulse; tied 0 without the optional feature.

Behaviour:
- Reset (async, active-high):
  - All outputs go to 0 and the state goes to S_IDLE.
  - The round-robin pointer resets so requester 0 has top priority.
  - Reset asserted mid-frame abandons the frame at once. The arbiter does not wait for the transmitter.
- States: S_IDLE, S_LAUNCH, S_WAIT_DONE, S_GAP.
- S_IDLE:
  - If any i_Req_Valid bit is high at edge t, pick the first set bit searching upward from (last_grant+1) mod NUM_REQ, wrapping around.
  - At t+1: o_Req_Ready[k]=1 for exactly one cycle, o_Tx_Byte=byte k (latched at t), o_Grant_Id=k, o_Tx_DV=1, state S_LAUNCH.
  - The last_grant pointer updates to k.
- S_LAUNCH:
  - o_Tx_DV is held at 1 until i_Tx_Active=1 is sampled.
  - On that edge: o_Tx_DV=0 and state S_WAIT_DONE.
- S_WAIT_DONE:
  - On the rising edge of i_Tx_Done (registered previous value 0, current 1), go to S_GAP.
  - The second Done cycle is ignored.
- S_GAP:
  - Stay until i_Tx_Done=0 and i_Tx_Active=0 are both sampled, then go to S_IDLE.
  - This guarantees the transmitter is in its idle state before the next DV. Minimum 2 cycles.
- o_Tx_Byte is stable from the grant until the next grant. It changes only on the S_IDLE to S_LAUNCH transition.
- Requester protocol:
  - A requester holds Valid and Data stable until its Ready pulse.
  - Dropping Valid before grant withdraws the request without error.
  - After its Ready pulse, a requester may present the next byte on the following cycle.
  - Arbitration is sampled only in S_IDLE. Valid changes in other states are not seen until the next S_IDLE cycle.
- Fairness:
  - With all requesters continuously valid, grants cycle 0,1,2,3,0,...
  - No requester waits more than NUM_REQ-1 frames.
- Multiple simultaneous valids in S_IDLE: exactly one grant. No other Ready bit pulses.
- i_Tx_Done seen outside S_WAIT_DONE: ignored.
- Throughput: one byte per (transmitter frame + 3..4 arbiter cycles). The gap is S_IDLE plus S_GAP overhead.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to S_LAUNCH and increments in S_LAUNCH and S_WAIT_DONE.
  - If the counter reaches TIMEOUT_CLKS before a Done rising edge: o_Timeout=1 for one cycle, o_Tx_DV=0, state S_GAP.
  - The byte is dropped and not retried. The round-robin pointer still advances.
  - Counter width is sized for TIMEOUT_CLKS.
- Undefined:
  - No counter is built and o_Timeout is constant 0.
  - A stuck transmitter leaves the arbiter in S_LAUNCH or S_WAIT_DONE indefinitely.

Test Plan:
- Single request:
  - Stimulus: transmitter model at CLKS_PER_BIT=4; req2 valid with 0xA5 at edge t.
  - Response: Ready=4'b0100 and o_Tx_DV=1 at t+1; Byte=0xA5, Grant_Id=2; DV drops the cycle after Active seen; exactly one frame transmitted; Busy low after the gap.
- Fairness: all 4 requests held valid with bytes 0x10..0x13 after reset → transmit order 0x10,0x11,0x12,0x13,0x10; each Ready pulses once per grant.
- Done double-count: 2-cycle Done pulse → a single S_WAIT_DONE→S_GAP transition; the next DV appears only after Done=0 and Active=0.
- Withdrawal: req1 valid then dropped while req0 frame in flight; req3 valid → next grant is 3, and Ready[1] never pulses.
- Reset mid-frame: assert i_Reset during S_WAIT_DONE → all outputs 0 asynchronously; after release, req0 wins against req3 when both valid.
- Timeout (UART_TX_ARB_TIMEOUT_EN, TIMEOUT_CLKS=50): Active held 0 → o_Timeout pulses at exactly 50 clocks after launch, DV=0, next requester granted afterwards. Without the macro: o_Timeout stays 0 and Busy stays 1.
